nios2_fmeasure_poller: RTL and testbench
========================================

// Module: nios2_fmeasure_poller
// PURPOSE
//  Avalon-MM read initiator for the fmeasure_clk PIO responder: every POLL_DIV clocks it reads the
//  measured-frequency word at poll_addr and presents it as a registered sample with a 1-cycle valid.
//  Sits between the PIO slave port and the AGC logic, so gain control gets clock data without the CPU.
// PARAMETERS
//  DATA_W        32      read data width (matches PIO readdata)
//  ADDR_W        2       Avalon word address width
//  POLL_DIV      1000    clocks between poll ticks (>=8)
//  READ_LATENCY  1       fixed responder read latency in clocks (1..4)
//  WAIT_TIMEOUT  64      max waitrequest-high cycles before abort
// PORTS
//  clk              in   1       system clock
//  reset            in   1       asynchronous, active-high reset
//  enable           in   1       1 = polling runs; 0 = divider held at 0
//  poll_addr        in   ADDR_W  word address to read (0 = PIO data register)
//  clear_err        in   1       1-cycle pulse clears sticky error flags
//  avm_address      out  ADDR_W  Avalon address
//  avm_read         out  1       Avalon read strobe
//  avm_waitrequest  in   1       Avalon waitrequest
//  avm_readdata     in   DATA_W  Avalon read data
//  sample           out  DATA_W  last captured word
//  sample_valid     out  1       1-cycle pulse: sample updated
//  busy             out  1       transaction in flight (state != IDLE)
//  overrun_err      out  1       sticky: tick occurred while busy
//  timeout_err      out  1       sticky: waitrequest exceeded WAIT_TIMEOUT
// BEHAVIOUR
//  - Reset (async, any time incl. mid-transaction): all outputs 0, divider 0, state IDLE; avm_read drops immediately.
//  - Divider counts 0..POLL_DIV-1 while enable=1; tick when count==POLL_DIV-1, then wraps to 0.
//    enable=0: count forced to 0, no ticks; an in-flight transaction still completes.
//  - FSM IDLE -> REQ on tick. REQ: avm_read=1, avm_address=poll_addr latched at tick, held stable.
//    REQ -> WAIT on first cycle with avm_waitrequest=0 (accept cycle A); wait counter reset on entry to REQ.
//    REQ -> IDLE (abort, timeout_err=1, no sample) when waitrequest has been high WAIT_TIMEOUT cycles.
//    WAIT: count READ_LATENCY-1 cycles; readdata captured at end of cycle A+READ_LATENCY -> IDLE.
//  - Latency, zero wait: tick cycle T, avm_read high in T+1, sample/sample_valid in T+2+READ_LATENCY.
//  - avm_read is high only in REQ; deasserts the cycle after acceptance.
//  - Tick while busy: tick dropped, overrun_err=1, divider keeps running.
//  - clear_err coincident with a new error event: set wins.
//  - sample holds value until next capture; no capture on abort.
// CONFIGURATION
//  FMEASURE_POLL_CHANGE_EN defined: extra output change_pulse (1 bit, reset 0) pulses with sample_valid
//    only when captured word != previous sample; first capture after reset always pulses.
//  Not defined: port absent, no compare logic.
// STRUCTURE
//  Package nios2_fmeasure_pkg: FSM state enum (IDLE, REQ, WAIT), default DATA_W/ADDR_W,
//    READ_LATENCY max constant.
//  Sub-module nios2_fmeasure_tick_gen: POLL_DIV divider with enable, emits 1-cycle tick.
//  Top: FSM, wait/latency counters, capture register, sticky flags.
// TESTING
//  1 POLL_DIV=8, zero-wait responder returning 0x0001_86A0 -> sample=0x0001_86A0, sample_valid every 8 clks,
//    T+3 latency at READ_LATENCY=1.
//  2 waitrequest high 5 cycles -> avm_read high 6 cycles, address stable, sample captured 1 clk after accept.
//  3 waitrequest stuck high, WAIT_TIMEOUT=64 -> abort after 64 cycles, timeout_err=1, sample unchanged,
//    clear_err -> 0.
//  4 waitrequest 10 cycles with POLL_DIV=8 -> overrun_err=1, next tick issues normal read.
//  5 reset asserted in REQ -> avm_read=0 same cycle, all outputs 0; after release first read at count 7.
//  6 FMEASURE_POLL_CHANGE_EN: reads 5,5,7 -> change_pulse on 1st and 3rd sample only.

Source files
------------

// File: rtl/nios2_fmeasure_pkg.sv
// Shared types and defaults for the fmeasure_clk Avalon-MM poller.
package nios2_fmeasure_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_ADDR_W       = 2;
    localparam int unsigned MAX_READ_LATENCY = 4;

endpackage

// File: rtl/nios2_fmeasure_tick_gen.sv
// Poll divider: counts 0..POLL_DIV-1 while enabled, flags the terminal count as a 1-cycle tick.
module nios2_fmeasure_tick_gen #(
    parameter int unsigned POLL_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(POLL_DIV);

    logic [CNT_W-1:0] count;

    always_comb begin
        tick = enable && (count == CNT_W'(POLL_DIV - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/nios2_fmeasure_poller.sv
// Periodic Avalon-MM reader of the fmeasure_clk PIO word, presented as a registered sample.
// Optional FMEASURE_POLL_CHANGE_EN adds change_pulse (sample differs from the previous one).
import nios2_fmeasure_pkg::*;

module nios2_fmeasure_poller #(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned POLL_DIV     = 1000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WAIT_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] poll_addr,
    input  logic              clear_err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              busy,
    output logic              overrun_err,
`ifdef FMEASURE_POLL_CHANGE_EN
    output logic              timeout_err,
    output logic              change_pulse
`else
    output logic              timeout_err
`endif
);

    localparam int unsigned WCNT_W = $clog2(WAIT_TIMEOUT + 1);
    localparam int unsigned LCNT_W = $clog2(MAX_READ_LATENCY);

    state_t            state, state_nx;
    logic              tick;
    logic              abort;
    logic              capture;
    logic [WCNT_W-1:0] wait_cnt;
    logic [LCNT_W-1:0] lat_cnt;

    nios2_fmeasure_tick_gen #(
        .POLL_DIV(POLL_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        abort    = 1'b0;
        capture  = 1'b0;
        avm_read = (state == REQ);
        busy     = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (tick) state_nx = REQ;
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    state_nx = WAIT;
                end else if (wait_cnt == WCNT_W'(WAIT_TIMEOUT - 1)) begin
                    abort    = 1'b1;
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                // WAIT spans accept+1 .. accept+READ_LATENCY; readdata is valid in its last cycle
                if (lat_cnt == LCNT_W'(READ_LATENCY - 1)) begin
                    capture  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_address  <= '0;
            wait_cnt     <= '0;
            lat_cnt      <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun_err  <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            sample_valid <= capture;
            if (state == IDLE && tick) avm_address <= poll_addr;
            wait_cnt <= (state == REQ)  ? wait_cnt + 1'b1 : '0;
            lat_cnt  <= (state == WAIT) ? lat_cnt + 1'b1  : '0;
            if (capture) sample <= avm_readdata;

            if (tick && state != IDLE) overrun_err <= 1'b1;
            else if (clear_err)        overrun_err <= 1'b0;

            if (abort)          timeout_err <= 1'b1;
            else if (clear_err) timeout_err <= 1'b0;
        end
    end

`ifdef FMEASURE_POLL_CHANGE_EN
    logic have_sample;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            change_pulse <= 1'b0;
            have_sample  <= 1'b0;
        end else begin
            change_pulse <= capture && (!have_sample || avm_readdata != sample);
            if (capture) have_sample <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nios2_fmeasure_poller.sv
// Bench for nios2_fmeasure_poller: behavioural responder, cycle model and capture scoreboard.
module tb_nios2_fmeasure_poller;

    localparam int unsigned PD = 8;
    localparam int unsigned RL = 1;
    localparam int unsigned TO = 64;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        clear_err = 1'b0;
    logic [1:0]  poll_addr = 2'd0;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = JUNK;
    logic [31:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        overrun_err;
    logic        timeout_err;
`ifdef FMEASURE_POLL_CHANGE_EN
    logic        change_pulse;
`endif

    nios2_fmeasure_poller #(
        .DATA_W       (32),
        .ADDR_W       (2),
        .POLL_DIV     (PD),
        .READ_LATENCY (RL),
        .WAIT_TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .poll_addr       (poll_addr),
        .clear_err       (clear_err),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .sample          (sample),
        .sample_valid    (sample_valid),
        .busy            (busy),
        .overrun_err     (overrun_err),
`ifdef FMEASURE_POLL_CHANGE_EN
        .timeout_err     (timeout_err),
        .change_pulse    (change_pulse)
`else
        .timeout_err     (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    // responder state
    int          wr_hold = 0;
    int          rq_cnt = 0;
    int          rd_due = -1;
    logic [31:0] rd_data = '0;
    logic [31:0] resp_data = '0;
    // reference model state
    int          m_div = 0;
    int          m_phase = 0;
    int          m_wcnt = 0;
    int          m_lcnt = 0;
    logic [1:0]  m_addr = '0;
    logic        m_ovr = 1'b0;
    logic        m_to = 1'b0;
    logic        m_have = 1'b0;
    logic [31:0] m_prev = '0;
    logic        m_tick;
    logic        set_ovr;
    logic        set_to;
    logic        chg;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return avm_read;
            1:       return sample_valid;
            2:       return timeout_err;
            default: return overrun_err;
        endcase
    endfunction

    task automatic wait_for(input int which, input int maxc, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!sel(which) && n < maxc);
        check(tag, sel(which), 1);
    endtask

    // Responder, model and scoreboard all evaluate mid-cycle on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            m_div = 0; m_phase = 0; m_wcnt = 0; m_lcnt = 0; m_addr = '0;
            m_ovr = 0; m_to = 0; m_have = 0; m_prev = '0;
            sb.delete();
            rq_cnt = 0; rd_due = -1;
            avm_waitrequest = 1'b0;
            avm_readdata = JUNK;
            check("rst_read", avm_read, 0);
            check("rst_busy", busy, 0);
            check("rst_sample", sample, 0);
            check("rst_valid", sample_valid, 0);
            check("rst_errs", {overrun_err, timeout_err}, 0);
            check("rst_addr", avm_address, 0);
        end else begin
            avm_readdata = (cyc == rd_due) ? rd_data : JUNK;
            if (avm_read && rq_cnt < wr_hold) begin
                avm_waitrequest = 1'b1;
                rq_cnt++;
            end else begin
                avm_waitrequest = 1'b0;
                if (!avm_read) rq_cnt = 0;
            end
            if (avm_read && !avm_waitrequest) begin
                rd_due = cyc + RL;
                rd_data = resp_data;
            end

            check("read", avm_read, m_phase == 1);
            check("busy", busy, m_phase != 0);
            if (m_phase == 1) check("addr", avm_address, m_addr);
            check("ovr", overrun_err, m_ovr);
            check("tmo", timeout_err, m_to);

            chg = 1'b0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("sv_due", sample_valid, 1);
                chg = !m_have || e.data != m_prev;
                m_have = 1'b1;
                m_prev = e.data;
            end else begin
                check("sv_idle", sample_valid, 0);
            end
            check("sample_hold", sample, m_have ? m_prev : 32'd0);
`ifdef FMEASURE_POLL_CHANGE_EN
            check("chg", change_pulse, chg);
`endif

            m_tick = enable && (m_div == PD - 1);
            m_div = (!enable || m_tick) ? 0 : m_div + 1;
            set_ovr = m_tick && (m_phase != 0);
            set_to = 1'b0;
            case (m_phase)
                0: if (m_tick) begin
                    m_phase = 1;
                    m_wcnt = 0;
                    m_addr = poll_addr;
                end
                1: if (!avm_waitrequest) begin
                    sb.push_back('{data: resp_data, due: cyc + RL + 1});
                    m_phase = 2;
                    m_lcnt = 1;
                end else begin
                    m_wcnt++;
                    if (m_wcnt == TO) begin
                        set_to = 1'b1;
                        m_phase = 0;
                    end
                end
                default: if (m_lcnt == RL) m_phase = 0; else m_lcnt++;
            endcase
            m_ovr = set_ovr ? 1'b1 : (clear_err ? 1'b0 : m_ovr);
            m_to  = set_to  ? 1'b1 : (clear_err ? 1'b0 : m_to);
        end
    end

    initial begin
        int n;
        int t0;
        resp_data = 32'h0001_86A0;
        wr_hold = 0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        enable = 1'b1;

        // zero-wait polling
        wait_for(1, 40, "t1_v0");
        t0 = cyc;
        wait_for(1, 20, "t1_v1");
        check("t1_period", cyc - t0, PD);
        check("t1_data", sample, 32'h0001_86A0);

        // waitrequest for 5 cycles; address must stay at the value latched at tick
        poll_addr = 2'd2;
        wr_hold = 5;
        resp_data = 32'h0000_1234;
        wait_for(0, 20, "t2_req");
        poll_addr = 2'd1;
        n = 1;
        while (avm_read && n < 30) begin
            @(posedge clk);
            #1;
            if (avm_read) n++;
        end
        check("t2_read_len", n, 6);
        wait_for(1, 10, "t2_valid");
        check("t2_data", sample, 32'h0000_1234);
        check("t2_addr", avm_address, 2);

        // long waitrequest overlaps the next tick
        wr_hold = 10;
        wait_for(3, 60, "t4_ovr");
        wait_for(1, 30, "t4_v_slow");
        wr_hold = 0;
        resp_data = 32'h0000_0ABC;
        wait_for(1, 30, "t4_v_next");
        check("t4_data", sample, 32'h0000_0ABC);

        // stuck waitrequest: abort, sample untouched, then clear
        wr_hold = 1000;
        resp_data = 32'h5555_5555;
        wait_for(2, 120, "t3_tmo");
        check("t3_sample", sample, 32'h0000_0ABC);
        wr_hold = 0;
        clear_err = 1'b1;
        @(posedge clk);
        #1 clear_err = 1'b0;
        check("t3_tmo_clr", timeout_err, 0);
        check("t3_ovr_clr", overrun_err, 0);
        wait_for(1, 30, "t3_recover");
        check("t3_rec_data", sample, 32'h5555_5555);

        // asynchronous reset while a read is outstanding
        wr_hold = 3;
        wait_for(0, 20, "t5_req");
        #2 reset = 1'b1;
        #1;
        check("t5_read", avm_read, 0);
        check("t5_busy", busy, 0);
        check("t5_sample", sample, 0);
        check("t5_valid", sample_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        wr_hold = 0;
        resp_data = 32'd5;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!avm_read && n < 20);
        check("t5_first_read", n, PD);

`ifdef FMEASURE_POLL_CHANGE_EN
        wait_for(1, 20, "t6_v0");
        check("t6_chg0", change_pulse, 1);
        resp_data = 32'd5;
        wait_for(1, 20, "t6_v1");
        check("t6_chg1", change_pulse, 0);
        resp_data = 32'd7;
        wait_for(1, 20, "t6_v2");
        check("t6_chg2", change_pulse, 1);
`endif

        // disabled divider issues no reads; polling resumes after re-enable
        wait_for(1, 20, "t7_pre");
        enable = 1'b0;
        repeat (3 * PD) @(posedge clk);
        #1 enable = 1'b1;
        resp_data = 32'hCAFE_0001;
        wait_for(1, 30, "t7_resume");
        check("t7_data", sample, 32'hCAFE_0001);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
